// File: rtl/scan_sequencer.sv
// Purpose: homes a stepper-driven scan head, then alternates settle / CCD line capture / line-advance steps.
// Latency: start accepted -> HOMING on the next cycle; line_done -> ccd_en low and next state on the next cycle.
// Backpressure: none; start is ignored unless IDLE, line_done is ignored outside CAPTURE.
//
// Ports:
//   clk_100M, rst                  clock and asynchronous active-high reset
//   start, abort                   one-cycle scan request / cancel
//   num_lines, steps_per_line      scan geometry, captured on an accepted start
//   line_done                      end-of-readout pulse from the CCD timing block
//   mtr_nhome, mtr_nflt            asynchronous home switch and driver fault (active-low)
//   ccd_en                         line capture enable
//   mtr_nen/step/dir/nrst/slp      stepper driver controls
//   busy, done, fault, line_count  status
module scan_sequencer #(
  parameter int STEP_HALF      = 2500,
  parameter int SETTLE         = 10000,
  parameter int HOME_MAX_STEPS = 20000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_lines,
  input  logic [7:0]  steps_per_line,
  input  logic        line_done,
  input  logic        mtr_nhome,
  input  logic        mtr_nflt,
  output logic        ccd_en,
  output logic        mtr_nen,
  output logic        mtr_step,
  output logic        mtr_dir,
  output logic        mtr_nrst,
  output logic        mtr_slp,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] line_count
);

  // One timer serves both the step-pulse period and the settle wait.
  localparam int TW  = $clog2(2 * STEP_HALF + SETTLE + 1);
  // Pulse counter must hold both the homing limit and any steps_per_line value.
  localparam int PCW = $clog2(HOME_MAX_STEPS + 257);

  localparam logic [TW-1:0]  T_ONE      = TW'(1);
  localparam logic [TW-1:0]  T_HALF     = TW'(STEP_HALF);
  localparam logic [TW-1:0]  T_PER_END  = TW'(2 * STEP_HALF - 1);
  localparam logic [TW-1:0]  T_SET_END  = TW'(SETTLE - 1);
  localparam logic [PCW-1:0] P_ONE      = PCW'(1);
  localparam logic [PCW-1:0] P_HOME_MAX = PCW'(HOME_MAX_STEPS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HOMING, ST_SETTLE, ST_CAPTURE, ST_STEP, ST_DONE, ST_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [PCW-1:0]  pulse_cnt_q, pulse_next;
  logic [15:0]     num_lines_q, line_count_q, lc_next;
  logic [7:0]      spl_q;
  logic            done_zero_q;
  logic            nrst_q;
  logic [1:0]      nhome_sync, nflt_sync;
  logic            nhome_s, nflt_s;
  logic            stepping, pulse_end, home_skip, start_ok, lc_inc;

  // Two-flop synchronizers; idle (released) value is 1.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      nhome_sync <= 2'b11;
      nflt_sync  <= 2'b11;
    end else begin
      nhome_sync <= {nhome_sync[0], mtr_nhome};
      nflt_sync  <= {nflt_sync[0], mtr_nflt};
    end
  end

  assign nhome_s = nhome_sync[1];
  assign nflt_s  = nflt_sync[1];

  assign pulse_next = pulse_cnt_q + P_ONE;
  assign lc_next    = line_count_q + 16'd1;
  assign start_ok   = (state_q == ST_IDLE) && start;

  always_comb begin
    stepping  = (state_q == ST_HOMING) || (state_q == ST_STEP);
    // Each pulse decision is taken on the last low cycle so no pulse is ever cut short.
    pulse_end = stepping && (timer_q == T_PER_END);
    // Already home on entry: leave HOMING without starting a pulse.
    home_skip = (state_q == ST_HOMING) && (timer_q == '0) && (pulse_cnt_q == '0) && !nhome_s;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:    if (start && (num_lines != 16'd0)) state_d = ST_HOMING;
      ST_HOMING: begin
        if (home_skip) begin
          state_d = ST_SETTLE;
        end else if (pulse_end) begin
          if (!nhome_s)                       state_d = ST_SETTLE;
          else if (pulse_next == P_HOME_MAX)  state_d = ST_FAULT;
        end
      end
      ST_SETTLE:  if (timer_q == T_SET_END) state_d = ST_CAPTURE;
      ST_CAPTURE: if (line_done) state_d = (lc_next == num_lines_q) ? ST_DONE : ST_STEP;
      ST_STEP:    if (pulse_end && (pulse_next == {{(PCW-8){1'b0}}, spl_q})) state_d = ST_SETTLE;
      ST_DONE:    state_d = ST_IDLE;
      ST_FAULT:   if (abort && nflt_s) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE) && (state_q != ST_FAULT)) state_d = ST_IDLE;
    // Driver fault outranks everything, including abort and line_done.
    if (!nflt_s && (state_q != ST_IDLE)) state_d = ST_FAULT;
  end

  // Count a line only when the capture actually completes (not aborted, not faulted).
  assign lc_inc = (state_q == ST_CAPTURE) && line_done &&
                  ((state_d == ST_STEP) || (state_d == ST_DONE));

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      pulse_cnt_q  <= '0;
      num_lines_q  <= '0;
      spl_q        <= 8'd1;
      line_count_q <= '0;
      done_zero_q  <= 1'b0;
      nrst_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrst_q      <= 1'b1;
      done_zero_q <= start_ok && (num_lines == 16'd0);
      if (start_ok) begin
        num_lines_q  <= num_lines;
        spl_q        <= (steps_per_line == 8'd0) ? 8'd1 : steps_per_line;
        line_count_q <= '0;
      end else if (lc_inc) begin
        line_count_q <= lc_next;
      end
      if (state_d != state_q) begin
        timer_q     <= '0;
        pulse_cnt_q <= '0;
      end else if (pulse_end) begin
        timer_q     <= '0;
        pulse_cnt_q <= pulse_next;
      end else if (stepping || (state_q == ST_SETTLE)) begin
        timer_q <= timer_q + T_ONE;
      end
    end
  end

  // All outputs decode from async-reset registers, so rst forces them without a clock.
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault      = (state_q == ST_FAULT);
  assign ccd_en     = (state_q == ST_CAPTURE);
  assign mtr_nen    = !((state_q == ST_HOMING) || (state_q == ST_SETTLE) ||
                        (state_q == ST_CAPTURE) || (state_q == ST_STEP));
  assign mtr_slp    = ~mtr_nen;
  assign mtr_dir    = (state_q == ST_STEP);
  assign mtr_step   = stepping && (timer_q < T_HALF) && !home_skip;
  assign mtr_nrst   = nrst_q;
  assign done       = done_zero_q || ((state_q == ST_DONE) && !abort && nflt_s);
  assign line_count = line_count_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Purpose: self-checking bench for scan_sequencer with short timing parameters.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_scan_sequencer;
  localparam int SH = 4;
  localparam int ST = 8;
  localparam int HM = 16;

  logic        clk_100M = 1'b0;
  logic        rst, start, abort, line_done, mtr_nhome, mtr_nflt;
  logic [15:0] num_lines;
  logic [7:0]  steps_per_line;
  logic        ccd_en, mtr_nen, mtr_step, mtr_dir, mtr_nrst, mtr_slp, busy, done, fault;
  logic [15:0] line_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];   // expected line_count at each done pulse

  scan_sequencer #(.STEP_HALF(SH), .SETTLE(ST), .HOME_MAX_STEPS(HM)) dut (
    .clk_100M(clk_100M), .rst(rst), .start(start), .abort(abort),
    .num_lines(num_lines), .steps_per_line(steps_per_line), .line_done(line_done),
    .mtr_nhome(mtr_nhome), .mtr_nflt(mtr_nflt), .ccd_en(ccd_en), .mtr_nen(mtr_nen),
    .mtr_step(mtr_step), .mtr_dir(mtr_dir), .mtr_nrst(mtr_nrst), .mtr_slp(mtr_slp),
    .busy(busy), .done(done), .fault(fault), .line_count(line_count)
  );

  always #5 clk_100M = ~clk_100M;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Pulse-shape monitor, sampled 1 ns after each rising edge.
  int mon_pulses = 0, mon_dir0 = 0, mon_dir1 = 0, mon_bad_hi = 0, mon_bad_lo = 0;
  int mon_ccd = 0, mon_done = 0, mon_fall_to_ccd = -1;
  int hi_run = 0, lo_run = 0;
  bit lo_valid = 0, ccd_since = 0, p_step = 0, p_ccd = 0;

  always @(posedge clk_100M) begin
    #1;
    if (rst) begin
      lo_valid = 0; p_step = 0; p_ccd = 0;
    end else begin
      if (mtr_step && !p_step) begin
        mon_pulses++;
        if (mtr_dir) mon_dir1++; else mon_dir0++;
        if (lo_valid && !ccd_since && lo_run != SH) mon_bad_lo++;
        hi_run = 1; lo_valid = 0;
      end else if (mtr_step) begin
        hi_run++;
      end else if (p_step) begin
        if (hi_run != SH) mon_bad_hi++;
        lo_run = 1; lo_valid = 1; ccd_since = 0;
      end else if (lo_valid) begin
        lo_run++;
      end
      if (ccd_en && !p_ccd) begin
        mon_ccd++;
        if (lo_valid && !ccd_since) mon_fall_to_ccd = lo_run - 1;
        ccd_since = 1;
      end
      if (done) mon_done++;
      p_step = mtr_step; p_ccd = ccd_en;
    end
  end

  task automatic pulse_start(input logic [15:0] nl, input logic [7:0] spl);
    start = 1'b1; num_lines = nl; steps_per_line = spl;
    @(negedge clk_100M);
    start = 1'b0;
  endtask

  task automatic pulse_line_done(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk_100M);
    line_done = 1'b1;
    @(negedge clk_100M);
    line_done = 1'b0;
  endtask

  task automatic wait_ccd(input int budget, output bit ok);
    int n = 0;
    while (!ccd_en && n < budget) begin @(negedge clk_100M); n++; end
    ok = ccd_en;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk_100M); n++; end
    ok = done;
  endtask

  task automatic test_reset();
    logic [8:0] v;
    rst = 1'b1; start = 0; abort = 0; line_done = 0; mtr_nhome = 0; mtr_nflt = 1;
    num_lines = 0; steps_per_line = 0;
    repeat (2) @(negedge clk_100M);
    v = {ccd_en, mtr_nen, mtr_step, mtr_dir, mtr_nrst, mtr_slp, busy, done, fault};
    checks++; if (v !== 9'b010000000) begin errors++; $display("FAIL reset_outputs: got %b want 010000000", v); end
    checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL reset_line_count: got %0d want 0", line_count); end
    rst = 1'b0;
    @(negedge clk_100M);
    checks++; if (mtr_nrst !== 1'b1) begin errors++; $display("FAIL reset_nrst_release: got %b want 1", mtr_nrst); end
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic test_full_scan();
    int b_p = mon_pulses, b_d0 = mon_dir0, b_d1 = mon_dir1, b_hi = mon_bad_hi;
    int b_lo = mon_bad_lo, b_ccd = mon_ccd, b_done = mon_done, e;
    bit ok;
    exp_q.push_back(3);
    pulse_start(16'd3, 8'd2);
    for (int ln = 0; ln < 3; ln++) begin
      wait_ccd(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_ccd_wait line %0d: ccd_en %b want 1", ln, ccd_en); end
      pulse_line_done(4);
      checks++; if (ccd_en !== 1'b0) begin errors++; $display("FAIL full_ccd_drop line %0d: got %b want 0", ln, ccd_en); end
    end
    wait_done(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done_wait: done %b want 1", done); end
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (line_count !== 16'(e)) begin errors++; $display("FAIL full_line_count: got %0d want %0d", line_count, e); end
    end
    repeat (4) @(negedge clk_100M);
    checks++; if (mon_done - b_done != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", mon_done - b_done); end
    checks++; if (mon_pulses - b_p != 4) begin errors++; $display("FAIL full_pulses: got %0d want 4", mon_pulses - b_p); end
    checks++; if (mon_dir1 - b_d1 != 4 || mon_dir0 != b_d0) begin errors++; $display("FAIL full_dir: dir1 %0d dir0 %0d want 4/0", mon_dir1 - b_d1, mon_dir0 - b_d0); end
    checks++; if (mon_bad_hi != b_hi || mon_bad_lo != b_lo) begin errors++; $display("FAIL full_pulse_shape: bad_hi %0d bad_lo %0d want 0/0", mon_bad_hi - b_hi, mon_bad_lo - b_lo); end
    checks++; if (mon_ccd - b_ccd != 3) begin errors++; $display("FAIL full_ccd_windows: got %0d want 3", mon_ccd - b_ccd); end
    // last low phase of a step burst plus the settle wait
    checks++; if (mon_fall_to_ccd != SH + ST) begin errors++; $display("FAIL full_fall_to_ccd: got %0d want %0d", mon_fall_to_ccd, SH + ST); end
    checks++; if (busy !== 1'b0 || line_count !== 16'd3) begin errors++; $display("FAIL full_idle: busy %b line_count %0d want 0/3", busy, line_count); end
  endtask

  task automatic test_homing();
    int b_p, b_d0, b_d1, b_hi, b_lo, falls = 0, n = 0, e;
    bit ok, prev = 0;
    mtr_nhome = 1'b1;
    repeat (3) @(negedge clk_100M);
    b_p = mon_pulses; b_d0 = mon_dir0; b_d1 = mon_dir1; b_hi = mon_bad_hi; b_lo = mon_bad_lo;
    exp_q.push_back(1);
    pulse_start(16'd1, 8'd1);
    while (falls < 5 && n < 200) begin
      if (prev && !mtr_step) falls++;
      prev = mtr_step;
      if (falls < 5) begin @(negedge clk_100M); n++; end
    end
    mtr_nhome = 1'b0;
    wait_ccd(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL home_ccd_wait: ccd_en %b want 1", ccd_en); end
    checks++; if (mon_pulses - b_p != 5) begin errors++; $display("FAIL home_pulses: got %0d want 5", mon_pulses - b_p); end
    checks++; if (mon_dir0 - b_d0 != 5 || mon_dir1 != b_d1) begin errors++; $display("FAIL home_dir: dir0 %0d dir1 %0d want 5/0", mon_dir0 - b_d0, mon_dir1 - b_d1); end
    checks++; if (mon_bad_hi != b_hi || mon_bad_lo != b_lo) begin errors++; $display("FAIL home_pulse_shape: bad_hi %0d bad_lo %0d want 0/0", mon_bad_hi - b_hi, mon_bad_lo - b_lo); end
    checks++; if (mon_fall_to_ccd != SH + ST) begin errors++; $display("FAIL home_settle: got %0d want %0d", mon_fall_to_ccd, SH + ST); end
    pulse_line_done(2);
    wait_done(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL home_done_wait: done %b want 1", done); end
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (line_count !== 16'(e)) begin errors++; $display("FAIL home_line_count: got %0d want %0d", line_count, e); end
    end
    repeat (2) @(negedge clk_100M);
  endtask

  task automatic test_home_fault();
    int b_p, n = 0;
    mtr_nhome = 1'b1;
    repeat (3) @(negedge clk_100M);
    b_p = mon_pulses;
    pulse_start(16'd1, 8'd1);
    while (!fault && n < 400) begin @(negedge clk_100M); n++; end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL homefault_fault: got %b want 1", fault); end
    checks++; if (mon_pulses - b_p != HM) begin errors++; $display("FAIL homefault_pulses: got %0d want %0d", mon_pulses - b_p, HM); end
    checks++; if (mtr_nen !== 1'b1 || mtr_step !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL homefault_idle: nen %b step %b busy %b want 1/0/0", mtr_nen, mtr_step, busy); end
    mtr_nhome = 1'b0;
    abort = 1'b1; @(negedge clk_100M); abort = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL homefault_clear: got %b want 0", fault); end
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic test_abort_step();
    int b_done, e;
    bit ok;
    pulse_start(16'd2, 8'd3);
    wait_ccd(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_ccd_wait: ccd_en %b want 1", ccd_en); end
    b_done = mon_done;
    pulse_line_done(1);
    @(negedge clk_100M);
    checks++; if (mtr_step !== 1'b1) begin errors++; $display("FAIL abort_mid_pulse: step %b want 1", mtr_step); end
    abort = 1'b1; @(negedge clk_100M); abort = 1'b0;
    checks++; if (mtr_step !== 1'b0 || mtr_nen !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_next: step %b nen %b busy %b done %b want 0/1/0/0", mtr_step, mtr_nen, busy, done);
    end
    repeat (3) @(negedge clk_100M);
    checks++; if (mon_done != b_done) begin errors++; $display("FAIL abort_no_done: got %0d want 0", mon_done - b_done); end
    exp_q.push_back(1);
    pulse_start(16'd1, 8'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart: busy %b want 1", busy); end
    wait_ccd(100, ok);
    pulse_line_done(2);
    wait_done(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_restart_done: done %b want 1", done); end
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (line_count !== 16'(e)) begin errors++; $display("FAIL abort_restart_count: got %0d want %0d", line_count, e); end
    end
    repeat (2) @(negedge clk_100M);
  endtask

  task automatic test_zero_and_ignored();
    int e;
    bit ok;
    exp_q.push_back(0);
    pulse_start(16'd0, 8'd5);
    checks++; if (done !== 1'b1 || mtr_nen !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done %b nen %b busy %b want 1/1/0", done, mtr_nen, busy);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (line_count !== 16'(e)) begin errors++; $display("FAIL zero_line_count: got %0d want %0d", line_count, e); end
    end
    @(negedge clk_100M);
    checks++; if (done !== 1'b0 || mtr_nen !== 1'b1) begin errors++; $display("FAIL zero_single: done %b nen %b want 0/1", done, mtr_nen); end
    pulse_start(16'd2, 8'd1);
    // both ignored: start while busy, line_done outside CAPTURE
    start = 1'b1; num_lines = 16'd1; line_done = 1'b1;
    @(negedge clk_100M);
    start = 1'b0; line_done = 1'b0;
    wait_ccd(100, ok);
    checks++; if (!ok || line_count !== 16'd0) begin errors++; $display("FAIL ignore_line_done: ccd %b count %0d want 1/0", ccd_en, line_count); end
    pulse_line_done(2);
    checks++; if (done !== 1'b0 || line_count !== 16'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL ignore_start: done %b count %0d busy %b want 0/1/1", done, line_count, busy);
    end
    wait_ccd(100, ok);
    @(negedge clk_100M);
    abort = 1'b1; line_done = 1'b1;
    @(negedge clk_100M);
    abort = 1'b0; line_done = 1'b0;
    checks++; if (line_count !== 16'd1 || busy !== 1'b0 || done !== 1'b0 || ccd_en !== 1'b0) begin
      errors++; $display("FAIL abort_vs_line_done: count %0d busy %b done %b ccd %b want 1/0/0/0", line_count, busy, done, ccd_en);
    end
    repeat (2) @(negedge clk_100M);
  endtask

  task automatic test_fault_capture();
    int n = 0;
    bit ok;
    pulse_start(16'd2, 8'd1);
    wait_ccd(100, ok);
    mtr_nflt = 1'b0;
    while (!fault && n < 3) begin @(negedge clk_100M); n++; end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL nflt_fault: got %b want 1 within 3 cycles", fault); end
    checks++; if (ccd_en !== 1'b0 || mtr_nen !== 1'b1) begin errors++; $display("FAIL nflt_outputs: ccd %b nen %b want 0/1", ccd_en, mtr_nen); end
    abort = 1'b1; @(negedge clk_100M); abort = 1'b0; @(negedge clk_100M);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL nflt_abort_low: fault %b want 1", fault); end
    mtr_nflt = 1'b1;
    repeat (3) @(negedge clk_100M);
    abort = 1'b1; @(negedge clk_100M); abort = 1'b0;
    checks++; if (fault !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nflt_abort_high: fault %b busy %b want 0/0", fault, busy); end
    repeat (2) @(negedge clk_100M);
  endtask

  task automatic test_rst_mid_step();
    bit ok;
    pulse_start(16'd2, 8'd3);
    wait_ccd(100, ok);
    pulse_line_done(1);
    @(negedge clk_100M);
    checks++; if (mtr_step !== 1'b1) begin errors++; $display("FAIL rst_pre_step: step %b want 1", mtr_step); end
    rst = 1'b1;
    #1;
    checks++; if (mtr_step !== 1'b0 || mtr_nen !== 1'b1 || busy !== 1'b0 || mtr_nrst !== 1'b0 || ccd_en !== 1'b0) begin
      errors++; $display("FAIL rst_async: step %b nen %b busy %b nrst %b ccd %b want 0/1/0/0/0", mtr_step, mtr_nen, busy, mtr_nrst, ccd_en);
    end
    @(negedge clk_100M);
    rst = 1'b0;
    @(negedge clk_100M);
    checks++; if (mtr_nrst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_release: nrst %b busy %b want 1/0", mtr_nrst, busy); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_homing();
    test_home_fault();
    test_abort_step();
    test_zero_and_ignored();
    test_fault_capture();
    test_rst_mid_step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
